// File: rtl/lstm_seq_ctrl.sv
// Sequencer around the combinational LSTM cell: drives X/c/h from registers, captures the cell result once per step.
// Latency: x handshake to h_valid is SETTLE_CYCLES+1 cycles; minimum step period is SETTLE_CYCLES+2 cycles.
// Backpressure: h_ready low holds the beat (h_data/c_data/h_last stable) and keeps x_ready low.
module lstm_seq_ctrl #(
    parameter int DATA_WIDTH    = 16,
    parameter int FRACT_WIDTH   = 8,
    parameter int SEQ_LEN_WIDTH = 8,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [SEQ_LEN_WIDTH-1:0] seq_len,
    input  logic                     x_valid,
    output logic                     x_ready,
    input  logic [DATA_WIDTH-1:0]    x_data,
    output logic [DATA_WIDTH-1:0]    cell_x,
    output logic [DATA_WIDTH-1:0]    cell_c_in,
    output logic [DATA_WIDTH-1:0]    cell_h_in,
    input  logic [DATA_WIDTH-1:0]    cell_c_out,
    input  logic [DATA_WIDTH-1:0]    cell_h_out,
    output logic                     h_valid,
    input  logic                     h_ready,
    output logic [DATA_WIDTH-1:0]    h_data,
    output logic [DATA_WIDTH-1:0]    c_data,
    output logic                     h_last,
    output logic [SEQ_LEN_WIDTH-1:0] step_idx,
    output logic                     busy,
    output logic                     done
);

    localparam int                       CNT_W    = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0]         CNT_INIT = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0]         CNT_ONE  = CNT_W'(1);
    localparam logic [SEQ_LEN_WIDTH-1:0] LEN_ONE  = SEQ_LEN_WIDTH'(1);

    // The cell's Q format must leave at least one integer bit, and the cell needs at least one settle cycle.
    if (SETTLE_CYCLES < 1 || FRACT_WIDTH >= DATA_WIDTH) begin : g_param_check
        $error("lstm_seq_ctrl: SETTLE_CYCLES must be >=1 and FRACT_WIDTH < DATA_WIDTH");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT_X = 2'd1,
        S_SETTLE = 2'd2,
        S_EMIT   = 2'd3
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [DATA_WIDTH-1:0]    r_x;
    logic [DATA_WIDTH-1:0]    r_c;
    logic [DATA_WIDTH-1:0]    r_h;
    logic [DATA_WIDTH-1:0]    r_h_data;
    logic [DATA_WIDTH-1:0]    r_c_data;
    logic [SEQ_LEN_WIDTH-1:0] r_step;
    logic [SEQ_LEN_WIDTH-1:0] r_len;
    logic [CNT_W-1:0]         r_cnt;
    logic                     r_done;
    logic                     w_last;
    logic                     w_x_ready;
    logic                     w_h_valid;
    logic                     w_busy;

    // Final step of the sequence; only meaningful while a non-zero length is loaded.
    assign w_last = (r_step == (r_len - LEN_ONE));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and stream handshake outputs, all decoded from the registered state.
    always_comb begin
        w_state_nxt = r_state;
        w_x_ready   = 1'b0;
        w_h_valid   = 1'b0;
        w_busy      = 1'b1;
        unique case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (start && (seq_len != '0)) begin
                    w_state_nxt = S_WAIT_X;
                end
            end
            S_WAIT_X: begin
                w_x_ready = 1'b1;
                if (x_valid) begin
                    w_state_nxt = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (r_cnt == CNT_ONE) begin
                    w_state_nxt = S_EMIT;
                end
            end
            S_EMIT: begin
                w_h_valid = 1'b1;
                if (h_ready) begin
                    w_state_nxt = w_last ? S_IDLE : S_WAIT_X;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: sample X, count settle time, capture the cell result, advance the step index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x      <= '0;
            r_c      <= '0;
            r_h      <= '0;
            r_h_data <= '0;
            r_c_data <= '0;
            r_step   <= '0;
            r_len    <= '0;
            r_cnt    <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_len  <= seq_len;
                        r_c    <= '0;
                        r_h    <= '0;
                        r_step <= '0;
                        // An empty sequence completes immediately without touching the stream.
                        if (seq_len == '0) begin
                            r_done <= 1'b1;
                        end
                    end
                end
                S_WAIT_X: begin
                    if (x_valid) begin
                        r_x   <= x_data;
                        r_cnt <= CNT_INIT;
                    end
                end
                S_SETTLE: begin
                    r_cnt <= r_cnt - CNT_ONE;
                    if (r_cnt == CNT_ONE) begin
                        r_c      <= cell_c_out;
                        r_h      <= cell_h_out;
                        r_c_data <= cell_c_out;
                        r_h_data <= cell_h_out;
                    end
                end
                S_EMIT: begin
                    if (h_ready) begin
                        if (w_last) begin
                            r_done <= 1'b1;
                            r_step <= '0;
                        end else begin
                            r_step <= r_step + LEN_ONE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign cell_x    = r_x;
    assign cell_c_in = r_c;
    assign cell_h_in = r_h;
    assign x_ready   = w_x_ready;
    assign h_valid   = w_h_valid;
    assign h_data    = r_h_data;
    assign c_data    = r_c_data;
    assign h_last    = w_h_valid && w_last;
    assign step_idx  = r_step;
    assign busy      = w_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_lstm_seq_ctrl.sv
`timescale 1ns/1ps
module tb_lstm_seq_ctrl;

    localparam int DW     = 16;
    localparam int SW     = 8;
    localparam int SETTLE = 2;

    typedef logic [DW-1:0] word_t;
    typedef word_t wq_t[$];

    typedef struct {
        int                  len;
        logic [3:0][DW-1:0]  x;
        logic [3:0][DW-1:0]  h;
        int                  sb;    // beat index to stall on (-1: none)
        int                  sc;    // stall cycles
        bit                  poke;  // pulse start while stalled
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [SW-1:0] seq_len;
    logic          x_valid;
    logic          x_ready;
    word_t         x_data;
    word_t         cell_x, cell_c_in, cell_h_in, cell_c_out, cell_h_out;
    logic          h_valid;
    logic          h_ready;
    word_t         h_data, c_data;
    logic          h_last;
    logic [SW-1:0] step_idx;
    logic          busy;
    logic          done;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Bench cell: c_out = c_in + X, h_out = h_in + X.
    assign cell_c_out = cell_c_in + cell_x;
    assign cell_h_out = cell_h_in + cell_x;

    lstm_seq_ctrl #(
        .DATA_WIDTH(DW), .FRACT_WIDTH(8), .SEQ_LEN_WIDTH(SW), .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .seq_len(seq_len),
        .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
        .cell_x(cell_x), .cell_c_in(cell_c_in), .cell_h_in(cell_h_in),
        .cell_c_out(cell_c_out), .cell_h_out(cell_h_out),
        .h_valid(h_valid), .h_ready(h_ready), .h_data(h_data), .c_data(c_data),
        .h_last(h_last), .step_idx(step_idx), .busy(busy), .done(done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: with the additive cell and zeroed state, h_t = c_t = running sum of X.
    function automatic wq_t prefix_sums(input wq_t xs);
        wq_t   r;
        word_t acc;
        acc = '0;
        foreach (xs[i]) begin
            acc = acc + xs[i];
            r.push_back(acc);
        end
        return r;
    endfunction

    function automatic vec_t mk(input int len, input word_t x0, input word_t x1, input word_t x2,
                                input word_t x3, input word_t h0, input word_t h1, input word_t h2,
                                input word_t h3, input int sb, input int sc, input bit poke);
        vec_t v;
        v.len = len;
        v.x[0] = x0; v.x[1] = x1; v.x[2] = x2; v.x[3] = x3;
        v.h[0] = h0; v.h[1] = h1; v.h[2] = h2; v.h[3] = h3;
        v.sb = sb; v.sc = sc; v.poke = poke;
        return v;
    endfunction

    task automatic recover();
        rst = 1'b1; start = 1'b0; x_valid = 1'b0; h_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_seq(input int len, input wq_t xs, input wq_t exps, input int sb,
                           input int sc, input int max_gap, input bit poke);
        int cyc;
        @(negedge clk);
        start   = 1'b1;
        seq_len = len[SW-1:0];
        @(negedge clk);
        start   = 1'b0;
        seq_len = SW'($urandom);   // changes after acceptance must be ignored
        if (len == 0) begin
            chk("zero_len_done", done, 1);
            chk("zero_len_busy", busy, 0);
            chk("zero_len_x_ready", x_ready, 0);
            chk("zero_len_h_valid", h_valid, 0);
            @(negedge clk);
            chk("zero_len_done_single", done, 0);
            chk("zero_len_h_valid2", h_valid, 0);
            return;
        end
        chk("busy_after_start", busy, 1);
        for (int k = 0; k < len; k++) begin
            repeat ($urandom_range(max_gap, 0)) begin
                chk("x_ready_idle_gap", x_ready, 1);
                @(negedge clk);
            end
            x_valid = 1'b1;
            x_data  = xs[k];
            cyc = 0;
            while (!x_ready && cyc < 8) begin
                @(negedge clk);
                cyc++;
            end
            chk("x_ready_wait", cyc, 0);
            if (!x_ready) begin recover(); return; end
            @(negedge clk);               // handshake edge has passed
            x_valid = 1'b0;
            for (int s = 0; s < SETTLE; s++) begin
                chk("settle_cell_x", cell_x, xs[k]);
                chk("settle_x_ready", x_ready, 0);
                chk("settle_h_valid", h_valid, 0);
                x_data = word_t'($urandom);
                @(negedge clk);
            end
            cyc = 0;
            while (!h_valid && cyc < 8) begin
                @(negedge clk);
                cyc++;
            end
            chk("h_valid_latency", cyc, 0);
            if (!h_valid) begin recover(); return; end
            if (k == sb) begin
                repeat (sc) begin
                    chk("stall_h_valid", h_valid, 1);
                    chk("stall_h_data", h_data, exps[k]);
                    chk("stall_h_last", h_last, (k == len - 1));
                    chk("stall_x_ready", x_ready, 0);
                    h_ready = 1'b0;
                    x_valid = 1'b1;
                    x_data  = word_t'($urandom);
                    start   = poke;
                    seq_len = SW'($urandom);
                    @(negedge clk);
                end
                start = 1'b0;
            end
            chk("beat_h_data", h_data, exps[k]);
            chk("beat_c_data", c_data, exps[k]);
            chk("beat_h_last", h_last, (k == len - 1));
            chk("beat_step_idx", step_idx, k);
            h_ready = 1'b1;
            x_valid = 1'b0;
            @(negedge clk);
            h_ready = 1'b0;
            chk("post_beat_h_valid", h_valid, 0);
            if (k != len - 1) chk("post_beat_done", done, 0);
        end
        chk("end_done", done, 1);
        chk("end_busy", busy, 0);
        chk("end_step_idx", step_idx, 0);
        @(negedge clk);
        chk("end_done_single", done, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  tbl[6];
        wq_t   xs, es;
        int    len;

        rst = 1'b1; start = 1'b0; seq_len = '0; x_valid = 1'b0; x_data = '0; h_ready = 1'b0;

        tbl[0] = mk(3, 16'h0100, 16'h0200, 16'h0080, 0, 16'h0100, 16'h0300, 16'h0380, 0, -1, 0, 0);
        tbl[1] = mk(3, 16'h0100, 16'h0200, 16'h0080, 0, 16'h0100, 16'h0300, 16'h0380, 0, 1, 5, 1);
        tbl[2] = mk(1, 16'h0010, 0, 0, 0, 16'h0010, 0, 0, 0, -1, 0, 0);
        tbl[3] = mk(1, 16'h0010, 0, 0, 0, 16'h0010, 0, 0, 0, 0, 2, 1);
        tbl[4] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, -1, 0, 0);
        tbl[5] = mk(4, 16'hFF00, 16'h0080, 16'h7F00, 16'h0200,
                       16'hFF00, 16'hFF80, 16'h7E80, 16'h8080, 3, 3, 0);

        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_x_ready", x_ready, 0);
        chk("rst_h_valid", h_valid, 0);
        chk("rst_h_last", h_last, 0);
        chk("rst_h_data", h_data, 0);
        chk("rst_step_idx", step_idx, 0);
        chk("rst_cell_h_in", cell_h_in, 0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            xs.delete(); es.delete();
            for (int j = 0; j < tbl[i].len; j++) begin
                xs.push_back(tbl[i].x[j]);
                es.push_back(tbl[i].h[j]);
            end
            run_seq(tbl[i].len, xs, es, tbl[i].sb, tbl[i].sc, 0, tbl[i].poke);
        end

        // Reset during SETTLE of step 1 abandons the sequence silently.
        @(negedge clk);
        start = 1'b1; seq_len = 8'd1;
        @(negedge clk);
        start = 1'b0; x_valid = 1'b1; x_data = 16'h1234;
        @(negedge clk);
        x_valid = 1'b0;
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_cell_x", cell_x, 16'h1234);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cell_x", cell_x, 0);
        chk("mid_rst_x_ready", x_ready, 0);
        chk("mid_rst_h_valid", h_valid, 0);
        chk("mid_rst_step_idx", step_idx, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_done", done, 0);
            chk("post_rst_h_valid", h_valid, 0);
        end
        xs = '{16'h0040};
        es = '{16'h0040};
        run_seq(1, xs, es, -1, 0, 0, 0);

        // Randomized sequences against the running-sum model.
        for (int r = 0; r < 10; r++) begin
            len = $urandom_range(6, 1);
            xs.delete();
            for (int j = 0; j < len; j++) xs.push_back(word_t'($urandom));
            es = prefix_sums(xs);
            run_seq(len, xs, es, $urandom_range(len - 1, 0), $urandom_range(4, 0), 2, r[0]);
        end

        // Maximum legal length: step_idx reaches 254 without wrapping.
        xs.delete();
        for (int j = 0; j < 255; j++) xs.push_back(word_t'($urandom_range(255, 0)));
        es = prefix_sums(xs);
        run_seq(255, xs, es, 254, 2, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
